matrix_result_collector: RTL and testbench

- Responder side of the multiplier result-output handshake (z_out/z_i/z_j/z_stb/z_ack).
- Accepts one result element per handshake and stores it into an internal N x N result buffer.
- Tracks which entries are filled, flags protocol errors, and asserts complete once all N*N distinct entries have arrived.
- Provides a registered random-access read port so the writer/dump logic can drain the matrix afterwards.

---
 rtl/matrix_result_collector_if.sv | 28 ++
 rtl/matrix_result_collector.sv | 165 ++++++++++++++++
 tb/tb_matrix_result_collector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_collector_if.sv
// Result-output handshake bundle between the multiplier (master) and the collector (slave).
interface matrix_result_collector_if #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic [W-1:0]  z_out;
    logic [IW-1:0] z_i;
    logic [IW-1:0] z_j;
    logic          z_stb;
    logic          z_ack;

    modport master (
        output z_out,
        output z_i,
        output z_j,
        output z_stb,
        input  z_ack
    );

    modport slave (
        input  z_out,
        input  z_i,
        input  z_j,
        input  z_stb,
        output z_ack
    );
endinterface

// File: rtl/matrix_result_collector.sv
// Collects N x N multiplier results over a four-phase handshake into a readable buffer.
// Optional row-major order checking is enabled by defining RESULT_ORDER_CHECK_EN.
module matrix_result_collector #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1,
    parameter int CW = $clog2(N * N + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    matrix_result_collector_if.slave     zif,
    input  logic [IW-1:0]                rd_i,
    input  logic [IW-1:0]                rd_j,
    output logic [W-1:0]                 rd_data,
    output logic [CW-1:0]                count,
    output logic                         complete,
    output logic                         dup_err,
    output logic                         range_err,
    output logic                         order_err
);
    localparam int CELLS = N * N;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ack_q;
    logic [W-1:0]     buffer [CELLS];
    logic [CELLS-1:0] filled;
    logic             commit;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_new;
    logic             wr_dup;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    function automatic logic [AW-1:0] flat_index(input logic [IW-1:0] i, input logic [IW-1:0] j);
        logic [31:0] t;
        t = 32'(i) * 32'(N) + 32'(j);
        return t[AW-1:0];
    endfunction

    // When the index width exactly covers 0..N-1 no index can be out of range.
    if ((2 ** IW) > N) begin : g_range_check
        assign wr_in_range = (zif.z_i < IW'(N)) && (zif.z_j < IW'(N));
        assign rd_in_range = (rd_i < IW'(N)) && (rd_j < IW'(N));
    end else begin : g_range_full
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end

    assign wr_idx   = flat_index(zif.z_i, zif.z_j);
    assign rd_idx   = flat_index(rd_i, rd_j);
    assign complete = (count == CW'(CELLS));
    assign zif.z_ack = ack_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= (state_next == ACK);
        end
    end

    // Only IDLE samples the strobe, so a strobe held through ACK/RELEASE commits once.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        wr_new     = 1'b0;
        wr_dup     = 1'b0;
        case (state)
            IDLE: begin
                if (zif.z_stb) begin
                    commit     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = RELEASE;
            RELEASE: begin
                if (!zif.z_stb) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (commit && wr_in_range) begin
            wr_new = !filled[wr_idx];
            wr_dup = filled[wr_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled    <= '0;
            count     <= '0;
            dup_err   <= 1'b0;
            range_err <= 1'b0;
        end else if (clear) begin
            filled    <= '0;
            count     <= '0;
            dup_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (wr_new) begin
                filled[wr_idx] <= 1'b1;
                count          <= count + CW'(1);
            end
            if (wr_dup) begin
                dup_err <= 1'b1;
            end
            if (commit && !wr_in_range) begin
                range_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_in_range && !clear) begin
            buffer[wr_idx] <= zif.z_out;
        end
    end

    // Unfilled entries read as zero; a same-cycle commit is seen on the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_in_range && filled[rd_idx]) begin
            rd_data <= buffer[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

`ifdef RESULT_ORDER_CHECK_EN
    logic [CW-1:0] exp_idx;

    // After a mismatch the expectation follows the producer rather than flagging every later element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_idx   <= '0;
            order_err <= 1'b0;
        end else if (clear) begin
            exp_idx   <= '0;
            order_err <= 1'b0;
        end else if (commit && wr_in_range) begin
            if (CW'(wr_idx) != exp_idx) begin
                order_err <= 1'b1;
            end
            exp_idx <= CW'(wr_idx) + CW'(1);
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector: an N=4 instance for the main flow and an N=3 instance for range errors.
module tb_matrix_result_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic [1:0]  rd_i4, rd_j4, rd_i3, rd_j3;
    logic [31:0] rd_data4, rd_data3;
    logic [4:0]  count4;
    logic [3:0]  count3;
    logic        complete4, dup_err4, range_err4, order_err4;
    logic        complete3, dup_err3, range_err3, order_err3;

    int check_count = 0;
    int error_count = 0;
    int ack_pulses4 = 0;
    int ack_pulses3 = 0;
    int base;

`ifdef RESULT_ORDER_CHECK_EN
    localparam logic ORDER_EXP = 1'b1;
`else
    localparam logic ORDER_EXP = 1'b0;
`endif

    matrix_result_collector_if #(.N(4), .W(32), .IW(2)) z4 ();
    matrix_result_collector_if #(.N(3), .W(32), .IW(2)) z3 ();

    matrix_result_collector #(.N(4), .W(32), .IW(2), .CW(5)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .zif(z4.slave),
        .rd_i(rd_i4), .rd_j(rd_j4), .rd_data(rd_data4), .count(count4),
        .complete(complete4), .dup_err(dup_err4), .range_err(range_err4), .order_err(order_err4)
    );

    matrix_result_collector #(.N(3), .W(32), .IW(2), .CW(4)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .zif(z3.slave),
        .rd_i(rd_i3), .rd_j(rd_j3), .rd_data(rd_data3), .count(count3),
        .complete(complete3), .dup_err(dup_err3), .range_err(range_err3), .order_err(order_err3)
    );

    always @(negedge clk) begin
        if (z4.z_ack === 1'b1) ack_pulses4++;
        if (z3.z_ack === 1'b1) ack_pulses3++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one element on the selected instance, waits (bounded) for its ack, then releases.
    task automatic applyStimulus(input bit to3, input int i, input int j, input logic [31:0] val);
        bit ack_seen;
        ack_seen = 1'b0;
        if (to3) begin
            z3.z_i = 2'(i); z3.z_j = 2'(j); z3.z_out = val; z3.z_stb = 1'b1;
        end else begin
            z4.z_i = 2'(i); z4.z_j = 2'(j); z4.z_out = val; z4.z_stb = 1'b1;
        end
        for (int k = 0; k < 10 && !ack_seen; k++) begin
            @(negedge clk);
            if (to3 ? (z3.z_ack === 1'b1) : (z4.z_ack === 1'b1)) ack_seen = 1'b1;
        end
        z3.z_stb = 1'b0;
        z4.z_stb = 1'b0;
        checkOutput($sformatf("ack_seen(%0d,%0d)", i, j), 32'(ack_seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic readBack(input bit to3, input int i, input int j, input logic [31:0] expected);
        if (to3) begin
            rd_i3 = 2'(i); rd_j3 = 2'(j);
        end else begin
            rd_i4 = 2'(i); rd_j4 = 2'(j);
        end
        @(negedge clk);
        checkOutput($sformatf("rd%0d(%0d,%0d)", to3 ? 3 : 4, i, j), to3 ? rd_data3 : rd_data4, expected);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0;
        rd_i4 = '0; rd_j4 = '0; rd_i3 = '0; rd_j3 = '0;
        z4.z_out = '0; z4.z_i = '0; z4.z_j = '0; z4.z_stb = 1'b0;
        z3.z_out = '0; z3.z_i = '0; z3.z_j = '0; z3.z_stb = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_count", 32'(count4), 32'd0);
        checkOutput("rst_complete", 32'(complete4), 32'd0);
        checkOutput("rst_ack", 32'(z4.z_ack), 32'd0);
        checkOutput("rst_rd_data", rd_data4, 32'd0);
        checkOutput("rst_flags", {29'd0, dup_err4, range_err4, order_err4}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] row-major fill");
        base = ack_pulses4;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(1'b0, i, j, 32'(100 + i * 4 + j));
                if (i == 3 && j == 2) begin
                    checkOutput("count_15", 32'(count4), 32'd15);
                    checkOutput("complete_at_15", 32'(complete4), 32'd0);
                end
            end
        end
        checkOutput("fill_ack_pulses", 32'(ack_pulses4 - base), 32'd16);
        checkOutput("fill_count", 32'(count4), 32'd16);
        checkOutput("fill_complete", 32'(complete4), 32'd1);
        checkOutput("fill_flags", {29'd0, dup_err4, range_err4, order_err4}, 32'd0);
        readBack(1'b0, 2, 3, 32'd111);
        readBack(1'b0, 0, 0, 32'd100);
        readBack(1'b0, 3, 3, 32'd115);

        $display("[TB] held strobe");
        pulseClear();
        checkOutput("clear_count", 32'(count4), 32'd0);
        checkOutput("clear_complete", 32'(complete4), 32'd0);
        base = ack_pulses4;
        z4.z_i = 2'd1; z4.z_j = 2'd1; z4.z_out = 32'hDEAD; z4.z_stb = 1'b1;
        repeat (6) @(negedge clk);
        z4.z_stb = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("hold_ack_pulses", 32'(ack_pulses4 - base), 32'd1);
        checkOutput("hold_count", 32'(count4), 32'd1);
        checkOutput("hold_dup", 32'(dup_err4), 32'd0);
        readBack(1'b0, 1, 1, 32'hDEAD);

        $display("[TB] duplicate write");
        pulseClear();
        applyStimulus(1'b0, 0, 0, 32'd5);
        applyStimulus(1'b0, 0, 0, 32'd7);
        checkOutput("dup_count", 32'(count4), 32'd1);
        checkOutput("dup_flag", 32'(dup_err4), 32'd1);
        readBack(1'b0, 0, 0, 32'd7);
        readBack(1'b0, 3, 3, 32'd0);
        readBack(1'b0, 1, 1, 32'd0);

        $display("[TB] clear during commit");
        applyStimulus(1'b0, 0, 1, 32'd11);
        applyStimulus(1'b0, 0, 2, 32'd12);
        applyStimulus(1'b0, 0, 3, 32'd13);
        applyStimulus(1'b0, 1, 0, 32'd14);
        checkOutput("pre_clear_count", 32'(count4), 32'd5);
        checkOutput("pre_clear_dup", 32'(dup_err4), 32'd1);
        clear = 1'b1;
        fork
            applyStimulus(1'b0, 1, 1, 32'h66);
            begin
                @(negedge clk);
                clear = 1'b0;
            end
        join
        checkOutput("cc_count", 32'(count4), 32'd0);
        checkOutput("cc_flags", {29'd0, dup_err4, range_err4, order_err4}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                readBack(1'b0, i, j, 32'd0);
            end
        end

        $display("[TB] order check");
        pulseClear();
        applyStimulus(1'b0, 0, 0, 32'd1);
        applyStimulus(1'b0, 0, 1, 32'd2);
        checkOutput("order_in_seq", 32'(order_err4), 32'd0);
        applyStimulus(1'b0, 1, 0, 32'd3);
        checkOutput("order_skip", 32'(order_err4), 32'(ORDER_EXP));

        $display("[TB] range error on N=3");
        base = ack_pulses3;
        applyStimulus(1'b1, 3, 0, 32'd9);
        checkOutput("range_ack_pulses", 32'(ack_pulses3 - base), 32'd1);
        checkOutput("range_count", 32'(count3), 32'd0);
        checkOutput("range_flag", 32'(range_err3), 32'd1);
        checkOutput("range_dup", 32'(dup_err3), 32'd0);
        applyStimulus(1'b1, 2, 2, 32'h22);
        checkOutput("n3_count", 32'(count3), 32'd1);
        checkOutput("n3_complete", 32'(complete3), 32'd0);
        readBack(1'b1, 2, 2, 32'h22);
        readBack(1'b1, 3, 0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
